// File: rtl/ising_pkg.sv
// ising_pkg -- shared types and helpers for the Ising step scheduler.
//   sched_state_t : scheduler FSM states
//   idx_w()       : index width for N oscillators (never less than 1 bit)
//   sat_add()     : signed add that clamps to the w-bit signed range
//                   (operands must be sign-extended w-bit values, w <= 63)
package ising_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_WAIT_ROW,
    S_UPDATE,
    S_ADVANCE,
    S_FINISH
  } sched_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v)      return max_v;
    else if (sum < min_v) return min_v;
    else                  return sum;
  endfunction

endpackage

// File: rtl/ising_pair_counter.sv
// ising_pair_counter -- row (i) / column (j) index generator for coupling pairs.
//   clk, rst   : clock, synchronous active-high reset (i=j=0)
//   row0       : restart at row 0, first column
//   pair_adv   : step j to the next column of the current row
//   row_adv    : step i to the next row, j to that row's first column
//   i, j       : current pair indices
//   last_col   : j is the final column of row i
//   last_row   : i is the final row
// Build option ISING_SKIP_DIAG_EN: column j==i is skipped in every row.
module ising_pair_counter #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             row0,
  input  logic             pair_adv,
  input  logic             row_adv,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last_col,
  output logic             last_row
);

`ifdef ISING_SKIP_DIAG_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(N - 2);

  logic [IDX_W-1:0] j_inc;
  logic [IDX_W-1:0] j_step;
  logic [IDX_W-1:0] i_inc;

  // Row 0 with the diagonal skipped starts at column 1.
  function automatic logic [IDX_W-1:0] first_col(input logic [IDX_W-1:0] row);
    return (SKIP && row == '0) ? IDX_W'(1) : '0;
  endfunction

  assign j_inc    = j + 1'b1;
  assign j_step   = (SKIP && j_inc == i) ? j_inc + 1'b1 : j_inc;
  assign i_inc    = i + 1'b1;
  assign last_row = (i == MAX_IDX);
  // The last row's final non-diagonal column is N-2 when skipping.
  assign last_col = (SKIP && last_row) ? (j == PRE_LAST) : (j == MAX_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      i <= '0;
      j <= '0;
    end else if (row0) begin
      i <= '0;
      j <= first_col('0);
    end else if (row_adv) begin
      i <= i_inc;
      j <= first_col(i_inc);
    end else if (pair_adv) begin
      j <= j_step;
    end
  end

endmodule

// File: rtl/ising_step_scheduler.sv
// ising_step_scheduler -- sequences one Ising oscillator simulation run.
// Streams (i,j) coupling pairs row by row to the MAC datapath, requests a
// phase update per row once the datapath reports the row accumulated, and
// advances simulated time by delta_t per sweep until stop_time is reached.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : run request, honoured only in IDLE / FINISH
//   stop_time, delta_t   : signed fixed-point run limits, latched in INIT
//   pair_valid/ready     : pair handshake; pair_i, pair_j, pair_last payload
//   row_done             : datapath finished accumulating row pair_i
//   upd_valid/ready      : phase-update handshake; upd_idx = current row
//   step_done            : one-cycle pulse per completed sweep
//   sim_time, step_count : accumulated time (saturating), completed sweeps
//   busy, done           : run in progress / run complete
// Build option ISING_SKIP_DIAG_EN: self-coupling pairs (j==i) are not issued.
//
// state     | meaning
// IDLE      | waiting for start after reset
// INIT      | latch limits, clear time/count/indices, reject empty runs
// ISSUE     | stream pairs of row i
// WAIT_ROW  | last pair sent, waiting for row_done
// UPDATE    | request phase update of row i
// ADVANCE   | sweep complete, advance sim_time
// FINISH    | run complete, done held until start
module ising_step_scheduler
  import ising_pkg::*;
#(
  parameter  int N         = 16,
  parameter  int DATA_W    = 32,
  parameter  int FRAC_BITS = 16,
  localparam int IDX_W     = idx_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] stop_time,
  input  logic [DATA_W-1:0] delta_t,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [IDX_W-1:0]  pair_i,
  output logic [IDX_W-1:0]  pair_j,
  output logic              pair_last,
  input  logic              row_done,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [IDX_W-1:0]  upd_idx,
  output logic              step_done,
  output logic [DATA_W-1:0] sim_time,
  output logic [DATA_W-1:0] step_count,
  output logic              busy,
  output logic              done
);

  if (N < 2 || FRAC_BITS >= DATA_W || DATA_W > 63) begin : g_bad_cfg
    $error("ising_step_scheduler: unsupported N / DATA_W / FRAC_BITS");
  end

  sched_state_t state_q, state_d;

  logic signed [DATA_W-1:0] sim_q;
  logic signed [DATA_W-1:0] sim_next;
  logic signed [DATA_W-1:0] dt_q;
  logic signed [DATA_W-1:0] stop_q;
  logic [DATA_W-1:0]        cnt_q;

  logic             row0, pair_adv, row_adv;
  logic             last_col, last_row;
  logic [IDX_W-1:0] i, j;
  logic             bad_limits;

  ising_pair_counter #(.N(N), .IDX_W(IDX_W)) u_pair_counter (
    .clk      (clk),
    .rst      (rst),
    .row0     (row0),
    .pair_adv (pair_adv),
    .row_adv  (row_adv),
    .i        (i),
    .j        (j),
    .last_col (last_col),
    .last_row (last_row)
  );

  assign sim_next   = $signed(DATA_W'(sat_add(64'(sim_q), 64'(dt_q), DATA_W)));
  // A non-positive step or end time means zero sweeps.
  assign bad_limits = delta_t[DATA_W-1] || (delta_t == '0) ||
                      stop_time[DATA_W-1] || (stop_time == '0);

  always_comb begin
    state_d  = state_q;
    row0     = 1'b0;
    pair_adv = 1'b0;
    row_adv  = 1'b0;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_INIT;
      S_INIT: begin
        row0    = 1'b1;
        state_d = bad_limits ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        if (pair_ready) begin
          // row_done coinciding with the last accept skips WAIT_ROW.
          if (last_col) state_d = row_done ? S_UPDATE : S_WAIT_ROW;
          else          pair_adv = 1'b1;
        end
      end
      S_WAIT_ROW: if (row_done) state_d = S_UPDATE;
      S_UPDATE: begin
        if (upd_ready) begin
          if (last_row) begin
            state_d = S_ADVANCE;
          end else begin
            row_adv = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ADVANCE: begin
        if (sim_next >= stop_q) begin
          state_d = S_FINISH;
        end else begin
          row0    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_FINISH:   if (start) state_d = S_INIT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sim_q   <= '0;
      cnt_q   <= '0;
      dt_q    <= '0;
      stop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        sim_q  <= '0;
        cnt_q  <= '0;
        dt_q   <= $signed(delta_t);
        stop_q <= $signed(stop_time);
      end else if (state_q == S_ADVANCE) begin
        sim_q <= sim_next;
        if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pair_valid = (state_q == S_ISSUE);
  assign pair_i     = i;
  assign pair_j     = j;
  assign pair_last  = pair_valid & last_col;
  assign upd_valid  = (state_q == S_UPDATE);
  assign upd_idx    = i;
  assign step_done  = (state_q == S_ADVANCE);
  assign sim_time   = sim_q;
  assign step_count = cnt_q;
  assign busy       = (state_q == S_INIT) || (state_q == S_ISSUE) ||
                      (state_q == S_WAIT_ROW) || (state_q == S_UPDATE) ||
                      (state_q == S_ADVANCE);
  assign done       = (state_q == S_FINISH);

endmodule
